// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths and RV32I B-type funct3 encodings for the branch resolve unit.
package branch_resolve_unit_pkg;

    localparam int unsigned REG_WIDTH = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator: one shared subtractor drives eq, signed lt
// and unsigned lt, from which all six RV32I conditions are selected by funct3.
module br_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned Width = REG_WIDTH
) (
    input  logic [2:0]       funct3,
    input  logic [Width-1:0] rs1,
    input  logic [Width-1:0] rs2,
    output logic             taken,
    output logic             illegal
);

    logic [Width:0] diff;
    logic           isEq;
    logic           isLtu;
    logic           isLt;

    // Extra MSB of the difference is the borrow, i.e. the unsigned rs1 < rs2 result.
    assign diff  = {1'b0, rs1} - {1'b0, rs2};
    assign isEq  = (diff[Width-1:0] == '0);
    assign isLtu = diff[Width];
    // With equal signs the unsigned order matches the signed one; otherwise the sign decides.
    assign isLt  = (rs1[Width-1] ^ rs2[Width-1]) ? rs1[Width-1] : isLtu;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = isEq;
            F3_BNE:  taken = ~isEq;
            F3_BLT:  taken = isLt;
            F3_BGE:  taken = ~isLt;
            F3_BLTU: taken = isLtu;
            F3_BGEU: taken = ~isLtu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: registered condition/target result behind a single-entry
// valid/ready stage with flush, plus saturating taken/total delivery counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN      = REG_WIDTH,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ALIGN_LSB = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_misalign,
    output logic            out_illegal,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    logic             condTaken;
    logic             condIllegal;
    logic [XLEN-1:0]  targetSum;
    logic             misalignD;
    logic             accept;
    logic             deliver;

    logic             validQ, validD;
    logic             takenQ;
    logic             illegalQ;
    logic             misalignQ;
    logic [XLEN-1:0]  targetQ;
    logic [CNT_W-1:0] takenCntQ, takenCntD;
    logic [CNT_W-1:0] totalCntQ, totalCntD;

    br_cond_eval #(
        .Width (XLEN)
    ) uCondEval (
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .taken   (condTaken),
        .illegal (condIllegal)
    );

    assign targetSum = pc + imm;
    assign misalignD = condTaken & (targetSum[ALIGN_LSB-1:0] != '0);

    assign in_ready = ~validQ | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign deliver  = validQ & out_ready & ~flush;

    always_comb begin
        validD = validQ;
        if (flush) begin
            validD = 1'b0;
        end else if (accept) begin
            validD = 1'b1;
        end else if (out_ready) begin
            validD = 1'b0;
        end
    end

    always_comb begin
        takenCntD = takenCntQ;
        totalCntD = totalCntQ;
        if (deliver) begin
            if (totalCntQ != '1) begin
                totalCntD = totalCntQ + CNT_W'(1);
            end
            if (takenQ && (takenCntQ != '1)) begin
                takenCntD = takenCntQ + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ    <= 1'b0;
            takenQ    <= 1'b0;
            illegalQ  <= 1'b0;
            misalignQ <= 1'b0;
            targetQ   <= '0;
            takenCntQ <= '0;
            totalCntQ <= '0;
        end else begin
            validQ    <= validD;
            takenCntQ <= takenCntD;
            totalCntQ <= totalCntD;
            if (accept) begin
                takenQ    <= condTaken;
                illegalQ  <= condIllegal;
                misalignQ <= misalignD;
                targetQ   <= targetSum;
            end
        end
    end

    assign out_valid    = validQ;
    assign out_taken    = takenQ;
    assign out_illegal  = illegalQ;
    assign out_misalign = misalignQ;
    assign out_target   = targetQ;
    assign taken_cnt    = takenCntQ;
    assign total_cnt    = totalCntQ;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a default-width instance and a CNT_W=2 instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        flush;
    logic        out_ready;

    logic        inReady, outValid, outTaken, outMisalign, outIllegal;
    logic [31:0] outTarget;
    logic [15:0] takenCnt, totalCnt;

    logic        sInReady, sOutValid, sOutTaken, sOutMisalign, sOutIllegal;
    logic [31:0] sOutTarget;
    logic [1:0]  sTakenCnt, sTotalCnt;

    int nCompared = 0;
    int nMismatch = 0;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (inReady),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .pc           (pc),
        .imm          (imm),
        .flush        (flush),
        .out_valid    (outValid),
        .out_ready    (out_ready),
        .out_taken    (outTaken),
        .out_target   (outTarget),
        .out_misalign (outMisalign),
        .out_illegal  (outIllegal),
        .taken_cnt    (takenCnt),
        .total_cnt    (totalCnt)
    );

    branch_resolve_unit #(
        .CNT_W (2)
    ) dutSat (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (sInReady),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .pc           (pc),
        .imm          (imm),
        .flush        (flush),
        .out_valid    (sOutValid),
        .out_ready    (out_ready),
        .out_taken    (sOutTaken),
        .out_target   (sOutTarget),
        .out_misalign (sOutMisalign),
        .out_illegal  (sOutIllegal),
        .taken_cnt    (sTakenCnt),
        .total_cnt    (sTotalCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish before 200000");
        $fatal(1);
    end

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] i);
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        pc       = p;
        imm      = i;
        in_valid = 1'b1;
    endtask

    // Accept one request with out_ready=1, check the registered result, then let it drain.
    task automatic runBranch(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                             input logic expTaken, input logic [31:0] expTarget,
                             input logic expMis, input logic expIll);
        drive(f3, a, b, p, i);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checkEq({tag, ".valid"},    32'(outValid),    32'd1);
        checkEq({tag, ".taken"},    32'(outTaken),    32'(expTaken));
        checkEq({tag, ".target"},   outTarget,        expTarget);
        checkEq({tag, ".misalign"}, 32'(outMisalign), 32'(expMis));
        checkEq({tag, ".illegal"},  32'(outIllegal),  32'(expIll));
        step();
        checkEq({tag, ".drained"},  32'(outValid),    32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        funct3    = 3'b000;
        rs1       = '0;
        rs2       = '0;
        pc        = '0;
        imm       = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        step();
        checkEq("rst.valid",    32'(outValid),    32'd0);
        checkEq("rst.taken",    32'(outTaken),    32'd0);
        checkEq("rst.target",   outTarget,        32'd0);
        checkEq("rst.misalign", 32'(outMisalign), 32'd0);
        checkEq("rst.illegal",  32'(outIllegal),  32'd0);
        checkEq("rst.takenCnt", 32'(takenCnt),    32'd0);
        checkEq("rst.totalCnt", 32'(totalCnt),    32'd0);
        rst_n = 1'b1;
        step();
        checkEq("rst.inReady",  32'(inReady),     32'd1);

        // BEQ equal operands
        runBranch("beq", 3'b000, 32'd3, 32'd3, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0, 1'b0);
        checkEq("beq.takenCnt", 32'(takenCnt), 32'd1);
        checkEq("beq.totalCnt", 32'(totalCnt), 32'd1);

        // BLT then BLTU back to back with the same operands
        drive(3'b100, 32'd100, 32'hFFFF_FF9C, 32'h400, 32'h10);
        step();
        checkEq("blt.valid",  32'(outValid), 32'd1);
        checkEq("blt.taken",  32'(outTaken), 32'd0);
        checkEq("blt.target", outTarget,     32'h410);
        drive(3'b110, 32'd100, 32'hFFFF_FF9C, 32'h400, 32'h10);
        step();
        in_valid = 1'b0;
        checkEq("bltu.valid", 32'(outValid), 32'd1);
        checkEq("bltu.taken", 32'(outTaken), 32'd1);
        step();
        checkEq("bltu.drained",  32'(outValid), 32'd0);
        checkEq("bltu.takenCnt", 32'(takenCnt), 32'd2);
        checkEq("bltu.totalCnt", 32'(totalCnt), 32'd3);

        // Illegal funct3 still delivered, counted in total only
        runBranch("ill", 3'b010, 32'd1, 32'd1, 32'h500, 32'h8, 1'b0, 32'h508, 1'b0, 1'b1);
        checkEq("ill.takenCnt", 32'(takenCnt), 32'd2);
        checkEq("ill.totalCnt", 32'(totalCnt), 32'd4);

        // BNE held for 3 cycles while a competing request waits
        out_ready = 1'b0;
        drive(3'b001, 32'd5, 32'd6, 32'h200, 32'h40);
        step();
        drive(3'b000, 32'd1, 32'd2, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            checkEq("hold.inReady",  32'(inReady),   32'd0);
            checkEq("hold.valid",    32'(outValid),  32'd1);
            checkEq("hold.taken",    32'(outTaken),  32'd1);
            checkEq("hold.target",   outTarget,      32'h240);
            checkEq("hold.totalCnt", 32'(totalCnt),  32'd4);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkEq("hold.drained",  32'(outValid), 32'd0);
        checkEq("hold.takenCnt", 32'(takenCnt), 32'd3);
        checkEq("hold.totalCnt", 32'(totalCnt), 32'd5);
        step();
        checkEq("hold.once",     32'(totalCnt), 32'd5);

        // Flush with a same-cycle request while a result is held
        out_ready = 1'b0;
        drive(3'b000, 32'd7, 32'd7, 32'h300, 32'h8);
        step();
        checkEq("flush.held", 32'(outValid), 32'd1);
        drive(3'b001, 32'd1, 32'd2, 32'h600, 32'h4);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkEq("flush.valid", 32'(outValid), 32'd0);
        out_ready = 1'b1;
        step();
        checkEq("flush.valid2",   32'(outValid), 32'd0);
        checkEq("flush.takenCnt", 32'(takenCnt), 32'd3);
        checkEq("flush.totalCnt", 32'(totalCnt), 32'd5);

        // Five more taken branches: narrow counters must sit at 3
        for (int k = 0; k < 5; k++) begin
            runBranch("sat", 3'b111, 32'd9, 32'd9, 32'h1000, 32'h4, 1'b1, 32'h1004, 1'b0,
                      1'b0);
        end
        checkEq("sat.takenCnt",  32'(sTakenCnt), 32'd3);
        checkEq("sat.totalCnt",  32'(sTotalCnt), 32'd3);
        checkEq("wide.takenCnt", 32'(takenCnt),  32'd8);
        checkEq("wide.totalCnt", 32'(totalCnt),  32'd10);

        runBranch("wrap",   3'b000, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h14, 1'b1, 32'h4, 1'b0,
                  1'b0);
        runBranch("mis",    3'b111, 32'd5, 32'd3, 32'h100, 32'h2, 1'b1, 32'h102, 1'b1, 1'b0);
        runBranch("misNt",  3'b100, 32'd5, 32'd3, 32'h100, 32'h2, 1'b0, 32'h102, 1'b0, 1'b0);
        runBranch("bgeNeg", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h8, 1'b0, 32'h8, 1'b0,
                  1'b0);
        runBranch("bgeEq",  3'b101, 32'd5, 32'd5, 32'h0, 32'h8, 1'b1, 32'h8, 1'b0, 1'b0);
        checkEq("end.takenCnt",  32'(takenCnt),  32'd11);
        checkEq("end.totalCnt",  32'(totalCnt),  32'd15);
        checkEq("end.satTaken",  32'(sTakenCnt), 32'd3);
        checkEq("end.satTotal",  32'(sTotalCnt), 32'd3);

        // Async reset while a result is held
        out_ready = 1'b0;
        drive(3'b000, 32'd1, 32'd1, 32'h700, 32'h10);
        step();
        in_valid = 1'b0;
        checkEq("arst.held", 32'(outValid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("arst.valid",    32'(outValid), 32'd0);
        checkEq("arst.target",   outTarget,     32'd0);
        checkEq("arst.takenCnt", 32'(takenCnt), 32'd0);
        checkEq("arst.totalCnt", 32'(totalCnt), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        checkEq("arst.inReady", 32'(inReady), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
